// File: rtl/mux4_sched_pkg.sv
// rtl/mux4_sched_pkg.sv - shared types and constants for the 4-channel mux select scheduler
package mux4_sched_pkg;

    localparam int NUM_CH      = 4;
    localparam int SEL_W       = 2;
    localparam int DWELL_W_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } sched_state_e;

    function automatic logic [NUM_CH-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_next_pick.sv
// rtl/rr_next_pick.sv - round-robin next-channel search after ptr
// MUX4_SCHED_SKIP_IDLE_EN: skip channels whose req bit is low; otherwise always ptr+1.
module rr_next_pick
    import mux4_sched_pkg::*;
(
    input  logic [SEL_W-1:0]  ptr_i,
    input  logic [NUM_CH-1:0] req_i,
    output logic [SEL_W-1:0]  pick_o,
    output logic              found_o
);

`ifdef MUX4_SCHED_SKIP_IDLE_EN
    logic [SEL_W-1:0] cand;

    // Search order ptr+1, ptr+2, ptr+3, ptr; the current channel is the last resort.
    always_comb begin
        pick_o  = ptr_i;
        found_o = 1'b0;
        cand    = ptr_i;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = ptr_i + k[SEL_W-1:0];
            if (!found_o && req_i[cand]) begin
                pick_o  = cand;
                found_o = 1'b1;
            end
        end
    end
`else
    logic unused_req;

    assign unused_req = ^req_i;
    assign pick_o     = ptr_i + 1'b1;
    assign found_o    = 1'b1;
`endif

endmodule

// File: rtl/mux4_sel_scheduler.sv
// rtl/mux4_sel_scheduler.sv - round-robin select driver for a 4:1 mux with dwell and ack handshake
// MUX4_SCHED_SKIP_IDLE_EN: channels without a pending request are skipped.
module mux4_sel_scheduler
    import mux4_sched_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [NUM_CH-1:0]  req_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic               ack_i,
    output logic               s1_o,
    output logic               s0_o,
    output logic [NUM_CH-1:0]  grant_o,
    output logic               valid_o,
    output logic               round_done_o
);

    sched_state_e      state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic              round_done_q, round_done_d;

    logic [SEL_W-1:0]  pick;
    logic              found;
    logic              load;

    rr_next_pick u_next_pick (
        .ptr_i   (ptr_q),
        .req_i   (req_i),
        .pick_o  (pick),
        .found_o (found)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            ptr_q        <= SEL_W'(NUM_CH - 1);
            cnt_q        <= '0;
            sel_q        <= '0;
            grant_q      <= '0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            grant_q      <= grant_d;
            round_done_q <= round_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        grant_d      = grant_q;
        round_done_d = 1'b0;
        load         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en_i && found) begin
                    load = 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (ack_i) begin
                    // Slot end: chain straight into the next slot, or fall back to idle.
                    if (en_i && found) begin
                        load         = 1'b1;
                        round_done_d = (pick <= ptr_q);
                    end else begin
                        state_d      = ST_IDLE;
                        grant_d      = '0;
                        round_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            state_d = ST_HOLD;
            ptr_d   = pick;
            cnt_d   = dwell_i;
            sel_d   = pick;
            grant_d = sel_to_onehot(pick);
        end
    end

    assign s1_o         = sel_q[1];
    assign s0_o         = sel_q[0];
    assign grant_o      = grant_q;
    assign valid_o      = (state_q == ST_HOLD);
    assign round_done_o = round_done_q;

endmodule
